// File: rtl/peripheral_bus_controller.sv
// rtl/peripheral_bus_controller.sv - CPU-bus register block for keypad FIFO, display register, control and irq
module peripheral_bus_controller #(
   parameter int DATA_W     = 32,
   parameter int KEY_W      = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] din,
   input  logic              writeEnable,
   input  logic              readEnable,
   output logic [DATA_W-1:0] dout,
   input  logic [KEY_W-1:0]  key_code,
   input  logic              key_valid,
   output logic [DATA_W-1:0] display_data,
   output logic              irq
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [ADDR_W-1:0] A_KEYDATA = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_DISPLAY = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(8);

   logic [KEY_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              irq_en;

   logic              empty, full;
   logic              pop, push, flush, ovf_clr, ovf_set;
   logic              wr_disp, wr_ctrl;
   logic [DATA_W-1:0] rdata;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign wr_disp = writeEnable && (address == A_DISPLAY);
   assign wr_ctrl = writeEnable && (address == A_CTRL);
   assign flush   = wr_ctrl && din[1];
   assign ovf_clr = wr_ctrl && din[2];
   assign pop     = readEnable && (address == A_KEYDATA) && !empty;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
   assign push    = key_valid && (!full || pop);
   assign ovf_set = key_valid && full && !pop && !flush;

   always_comb begin
      rdata = '0;
      case (address)
         A_KEYDATA: if (!empty) rdata[KEY_W-1:0] = mem[rd_ptr];
         A_STATUS: begin
            rdata[0]    = empty;
            rdata[1]    = full;
            rdata[2]    = overflow;
            rdata[15:8] = 8'(count);
         end
         A_DISPLAY: rdata = display_data;
         A_CTRL:    rdata[0] = irq_en;
         default:   rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= key_code;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout         <= '0;
         display_data <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow     <= 1'b0;
         irq_en       <= 1'b0;
         irq          <= 1'b0;
      end else begin
         if (readEnable) dout <= rdata;
         if (wr_disp)    display_data <= din;
         if (wr_ctrl)    irq_en <= din[0];
         overflow <= ovf_set | (overflow & ~ovf_clr);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
         end
         irq <= irq_en & (!empty | overflow);
      end
   end

endmodule

// File: tb/tb_peripheral_bus_controller.sv
// tb/tb_peripheral_bus_controller.sv - directed bench for peripheral_bus_controller
module tb_peripheral_bus_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  address = '0;
   logic [31:0] din = '0;
   logic        writeEnable = 1'b0;
   logic        readEnable = 1'b0;
   logic [31:0] dout;
   logic [7:0]  key_code = '0;
   logic        key_valid = 1'b0;
   logic [31:0] display_data;
   logic        irq;

   int checks = 0;
   int errors = 0;

   peripheral_bus_controller dut (
      .clk(clk), .reset(reset), .address(address), .din(din),
      .writeEnable(writeEnable), .readEnable(readEnable), .dout(dout),
      .key_code(key_code), .key_valid(key_valid),
      .display_data(display_data), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [3:0] a);
      address = a; readEnable = 1'b1;
      tick();
      readEnable = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      address = a; din = d; writeEnable = 1'b1;
      tick();
      writeEnable = 1'b0;
   endtask

   task automatic push(input logic [7:0] c);
      key_code = c; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
   endtask

   initial begin
      #12;
      chk("reset_dout", dout, 32'h0);
      chk("reset_display", display_data, 32'h0);
      chk("reset_irq", {31'b0, irq}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      tick();

      rd(4'h1);  chk("status_after_reset", dout, 32'h0000_0001);

      wr(4'h4, 32'h1234_5678);
      chk("display_after_write", display_data, 32'h1234_5678);
      rd(4'h4);  chk("display_readback", dout, 32'h1234_5678);

      push(8'h05); push(8'h0A); push(8'h0F);
      rd(4'h0);  chk("pop0", dout, 32'h05);
      rd(4'h0);  chk("pop1", dout, 32'h0A);
      rd(4'h0);  chk("pop2", dout, 32'h0F);
      rd(4'h0);  chk("pop_empty", dout, 32'h0);
      rd(4'h1);  chk("status_empty_again", dout, 32'h0000_0001);

      for (int i = 1; i <= 5; i++) push(8'(i));
      rd(4'h1);  chk("status_full_ovf", dout, 32'h0000_0406);
      for (int i = 1; i <= 4; i++) begin
         rd(4'h0); chk("drain", dout, 32'(i));
      end
      rd(4'h1);  chk("status_empty_ovf", dout, 32'h0000_0005);
      wr(4'h8, 32'h4);
      rd(4'h1);  chk("status_ovf_cleared", dout, 32'h0000_0001);
      rd(4'h8);  chk("ctrl_readback_zero", dout, 32'h0);

      wr(4'h8, 32'h1);
      rd(4'h8);  chk("ctrl_irq_en", dout, 32'h1);
      push(8'h07);
      chk("irq_not_yet", {31'b0, irq}, 32'h0);
      tick();
      chk("irq_set", {31'b0, irq}, 32'h1);
      rd(4'h0);  chk("pop_irq_code", dout, 32'h07);
      chk("irq_still_set", {31'b0, irq}, 32'h1);
      tick();
      chk("irq_cleared", {31'b0, irq}, 32'h0);

      push(8'h11); push(8'h12); push(8'h13); push(8'h14);
      key_code = 8'h09; key_valid = 1'b1;
      rd(4'h0);
      key_valid = 1'b0;
      chk("full_push_pop_head", dout, 32'h11);
      rd(4'h1);  chk("full_push_pop_status", dout, 32'h0000_0402);
      rd(4'h0);  chk("drain_12", dout, 32'h12);
      rd(4'h0);  chk("drain_13", dout, 32'h13);
      rd(4'h0);  chk("drain_14", dout, 32'h14);
      rd(4'h0);  chk("drain_09", dout, 32'h09);

      push(8'h21); push(8'h22);
      key_code = 8'h33; key_valid = 1'b1;
      wr(4'h8, 32'h3);
      key_valid = 1'b0;
      rd(4'h1);  chk("flush_status", dout, 32'h0000_0001);
      rd(4'h8);  chk("flush_reads_zero", dout, 32'h1);
      tick();
      chk("dout_holds", dout, 32'h1);

      wr(4'h2, 32'hDEAD_BEEF);
      rd(4'h2);  chk("unmapped_read", dout, 32'h0);
      chk("unmapped_write_ignored", display_data, 32'h1234_5678);

      address = 4'h4; din = 32'h0000_CAFE; writeEnable = 1'b1; readEnable = 1'b1;
      tick();
      writeEnable = 1'b0; readEnable = 1'b0;
      chk("rw_same_old", dout, 32'h1234_5678);
      chk("rw_same_new", display_data, 32'h0000_CAFE);

      push(8'h41); push(8'h42);
      rd(4'h0);  chk("pre_reset_pop", dout, 32'h41);
      chk("pre_reset_irq", {31'b0, irq}, 32'h1);
      key_code = 8'h55; key_valid = 1'b1;
      #1 reset = 1'b0;
      #2;
      chk("async_dout", dout, 32'h0);
      chk("async_display", display_data, 32'h0);
      chk("async_irq", {31'b0, irq}, 32'h0);
      tick();
      key_valid = 1'b0;
      reset = 1'b1;
      tick();
      rd(4'h1);  chk("post_reset_status", dout, 32'h0000_0001);
      rd(4'h8);  chk("post_reset_ctrl", dout, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
